sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Message-schedule stage of the SHA-256 accelerator, sitting directly upstream of the compression round datapath. Accepts one 512-bit padded message block, then streams the 64 schedule words W0..W63, one per accepted transfer, each tagged with its round index. Expansion uses a 16-word sliding window, so the round datapath can consume one word per cycle with no bubbles.

## Interface
- No parameters. Word width is 32, block width is 512 and round count is 64; all three are fixed by SHA-256.
- clk_i  in  1  clock; all state updates on the rising edge
- reset_n_i  in  1  synchronous, active-low reset
- block_i  in  512  padded message block; block_i[511:480] is M0 (big-endian word order)
- v_i  in  1  block_i is valid
- ready_o  out  1  block can be accepted this cycle
- wt_o  out  32  schedule word W[round_o]
- round_o  out  6  round index t, 0..63
- last_o  out  1  current word is W63
- v_o  out  1  wt_o, round_o and last_o are valid
- yumi_i  in  1  consumer takes the current word this cycle; legal only when v_o=1
- kt_o  out  32  round constant K[round_o]; present only with SHA256_SCHED_KT_EN

## Operation
- States and transitions:
  - IDLE: ready_o=1, v_o=0. v_i & ready_o loads window w[0..15] = M0..M15, clears the counter to 0 and moves to RUN.
  - RUN: ready_o=0, v_o=1, wt_o=w[0], round_o=counter.
  - In RUN, on yumi_i: shift w[i] <= w[i+1] for i=0..14, load w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0] mod 2^32, and increment the counter.
  - yumi_i while last_o=1 moves to IDLE.
- Small sigma functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- Arithmetic: the three additions wrap modulo 2^32 and carries are discarded.
- Words t<16 pass through unmodified. Expansion results are also computed during rounds 0..15; they are the correct W16.. values because the window is already full.
- last_o = (round_o==63) & v_o.
- In RUN, wt_o, round_o and kt_o stay stable while yumi_i=0.
- yumi_i while v_o=0 is ignored.
- v_i in RUN is ignored and the block is not captured. The producer holds block_i and v_i until ready_o.

## Timing
- Reset (reset_n_i=0 at an edge) puts the block in IDLE on the next cycle: ready_o=1, v_o=0, last_o=0, round_o=0, wt_o=0, kt_o=0, window cleared.
- Reset mid-block aborts the block; no further words are emitted.
- Load latency: the block is accepted at edge N; v_o=1 with W0 from cycle N+1.
- Throughput: with yumi_i held high, one word per cycle; W63 is presented in cycle N+64.
- Turnaround: yumi_i on W63 at edge M gives ready_o=1 in cycle M+1. The next block can load at edge M+1, so the minimum block period is 65 cycles.
- All outputs are registered or decode registered state only; there are no combinational paths from the inputs.

## Configuration
- SHA256_SCHED_KT_EN defined: the kt_o port exists and is driven from an internal 64-entry constant table indexed by the registered counter, aligned with wt_o.
- SHA256_SCHED_KT_EN undefined: no kt_o port and no table. The round datapath sources K itself from round_o.

## Structure
- Shared package sha256_pkg holds:
  - word and round-index typedefs
  - the 64-entry K constant array
  - the schedule state enum (IDLE, RUN)
  - ROUNDS=64 and WINDOW=16
- One sub-module, sha256_small_sigma: combinational σ0/σ1 selected by a parameter and instantiated twice. The window, counter and FSM stay in this block.

## Test plan
- Block "abc" (M0=0x61626380, M1..M14=0, M15=0x00000018), yumi_i held high:
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - All 64 words match a software model.
  - last_o is high only on round 63.
- Random yumi_i back-pressure, 50% duty:
  - The word sequence matches the full-rate run.
  - Outputs are stable while yumi_i=0; 64 transfers in total.
- v_i asserted throughout RUN with a different block_i: ignored; the second block loads only in the cycle after W63 is consumed, i.e. the 65-cycle period.
- reset_n_i=0 at round 30, with the previous block still valid on block_i and v_i dropped in the same cycle: the next cycle shows ready_o=1, v_o=0, round_o=0; a fresh block then restarts from W0.
- yumi_i pulsed while in IDLE: no state change and v_o stays 0.
- With SHA256_SCHED_KT_EN: kt_o=0x428A2F98 at round 0 and 0xC67178F2 at round 63. Without it, the build has no kt_o port.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round types, K round constants, schedule FSM states.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int ROUNDS  = 64;
  localparam int WINDOW  = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [5:0]        round_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

  localparam word_t K_TABLE [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t k_lookup(input round_t idx);
    return K_TABLE[idx];
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma: SEL_SIGMA1=0 gives sigma0, SEL_SIGMA1=1 gives sigma1.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter bit SEL_SIGMA1 = 1'b0
) (
  input  word_t x_i,
  output word_t y_o
);

  if (SEL_SIGMA1) begin : g_sigma1
    assign y_o = {x_i[16:0], x_i[31:17]} ^ {x_i[18:0], x_i[31:19]} ^ {10'b0, x_i[31:10]};
  end else begin : g_sigma0
    assign y_o = {x_i[6:0], x_i[31:7]} ^ {x_i[17:0], x_i[31:18]} ^ {3'b0, x_i[31:3]};
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block, streams W0..W63 through a 16-word window.
// Optional kt_o round-constant output is enabled by defining SHA256_SCHED_KT_EN.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [WORD_W-1:0]  wt_o,
  output logic [5:0]         round_o,
  output logic               last_o,
  output logic               v_o,
`ifdef SHA256_SCHED_KT_EN
  output logic [WORD_W-1:0]  kt_o,
`endif
  input  logic               yumi_i
);

  sched_state_e state_q, state_d;
  round_t       cnt_q, cnt_d;
  word_t        win_q [WINDOW];
  word_t        win_d [WINDOW];

  word_t sig0_s, sig1_s, expand_s;

  sha256_small_sigma #(.SEL_SIGMA1(1'b0)) u_sigma0 (
    .x_i (win_q[1]),
    .y_o (sig0_s)
  );

  sha256_small_sigma #(.SEL_SIGMA1(1'b1)) u_sigma1 (
    .x_i (win_q[14]),
    .y_o (sig1_s)
  );

  // W[t+16] from the window holding W[t..t+15]; carries beyond 32 bits drop.
  assign expand_s = sig1_s + win_q[9] + sig0_s + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (v_i) begin
          for (int i = 0; i < WINDOW; i++) begin
            win_d[i] = block_i[BLOCK_W-1-WORD_W*i -: WORD_W];
          end
          cnt_d   = 6'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (yumi_i) begin
          for (int i = 0; i < WINDOW-1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[WINDOW-1] = expand_s;
          cnt_d           = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      for (int i = 0; i < WINDOW; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < WINDOW; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign v_o     = (state_q == S_RUN);
  assign wt_o    = win_q[0];
  assign round_o = cnt_q;
  assign last_o  = (state_q == S_RUN) && (cnt_q == 6'd63);

`ifdef SHA256_SCHED_KT_EN
  // Forced to zero outside RUN so the idle/reset value is not K[0].
  assign kt_o = (state_q == S_RUN) ? k_lookup(cnt_q) : 32'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: expected W words are queued at load, popped on each transfer.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] block;
  logic         v_i;
  logic         ready;
  logic [31:0]  wt;
  logic [5:0]   rnd;
  logic         last;
  logic         v_o;
  logic         yumi;
`ifdef SHA256_SCHED_KT_EN
  logic [31:0]  kt;
`endif

  always #5 clk = ~clk;

  sha256_msg_schedule dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .block_i   (block),
    .v_i       (v_i),
    .ready_o   (ready),
    .wt_o      (wt),
    .round_o   (rnd),
    .last_o    (last),
    .v_o       (v_o),
`ifdef SHA256_SCHED_KT_EN
    .kt_o      (kt),
`endif
    .yumi_i    (yumi)
  );

  typedef struct packed {
    logic [31:0] wt;
    logic [5:0]  rnd;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   abc_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.wt   = w[t];
      e.rnd  = 6'(t);
      e.last = (t == 63);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge: waits for ready, then presents the block for the next edge.
  task automatic load_block(input logic [511:0] b);
    int w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("load_ready", ready, 1'b1);
    block = b;
    v_i   = 1'b1;
    push_block(b);
  endtask

  task automatic stream(input int duty, input bit hold_vi, input logic [511:0] other,
                        input int max_xfer, output int n_xfer);
    int   budget;
    exp_t e;
    n_xfer = 0;
    budget = 0;
    while (exp_q.size() > 0 && n_xfer < max_xfer && budget < 1000) begin
      @(negedge clk);
      budget++;
      v_i = hold_vi;
      if (hold_vi) block = other;
      e = exp_q[0];
      chk("v_o_run", v_o, 1'b1);
      chk("ready_run", ready, 1'b0);
      chk("wt", wt, e.wt);
      chk("round", rnd, e.rnd);
      chk("last", last, e.last);
      if (abc_mode && e.rnd == 6'd16) chk("abc_w16", wt, 32'h61626380);
      if (abc_mode && e.rnd == 6'd17) chk("abc_w17", wt, 32'h000F0000);
`ifdef SHA256_SCHED_KT_EN
      if (e.rnd == 6'd0)  chk("kt_r0", kt, 32'h428A2F98);
      if (e.rnd == 6'd63) chk("kt_r63", kt, 32'hC67178F2);
`endif
      yumi = (duty >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < duty);
      if (yumi) begin
        void'(exp_q.pop_front());
        n_xfer++;
      end
    end
    if (budget >= 1000) chk("stream_timeout", 1'b1, 1'b0);
  endtask

  logic [511:0] abc_blk, blk_a, blk_b;
  int n, t_load_a, t_load_b;

  initial begin
    reset_n = 1'b0;
    v_i     = 1'b0;
    yumi    = 1'b0;
    block   = '0;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) begin
      blk_a[511-32*i -: 32] = $urandom();
      blk_b[511-32*i -: 32] = $urandom();
    end

    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_round", rnd, 6'd0);
    chk("rst_wt", wt, 32'd0);
`ifdef SHA256_SCHED_KT_EN
    chk("rst_kt", kt, 32'd0);
`endif
    reset_n = 1'b1;

    // yumi pulses in IDLE must not start anything
    for (int i = 0; i < 3; i++) begin
      yumi = 1'b1;
      @(negedge clk);
      chk("idle_v_o", v_o, 1'b0);
      chk("idle_ready", ready, 1'b1);
      chk("idle_round", rnd, 6'd0);
    end
    yumi = 1'b0;

    // "abc" at full rate
    load_block(abc_blk);
    abc_mode = 1'b1;
    stream(100, 1'b0, '0, 64, n);
    abc_mode = 1'b0;
    chk("xfers_full", n, 64);
    @(negedge clk);
    yumi = 1'b0;
    chk("done_ready", ready, 1'b1);
    chk("done_v_o", v_o, 1'b0);

    // 50% back-pressure
    load_block(abc_blk);
    stream(50, 1'b0, '0, 64, n);
    chk("xfers_bp", n, 64);
    @(negedge clk);
    yumi = 1'b0;
    chk("bp_ready", ready, 1'b1);

    // v_i held with a different block during RUN: ignored until W63 is consumed
    load_block(blk_a);
    t_load_a = cyc;
    stream(100, 1'b1, blk_b, 64, n);
    chk("xfers_a", n, 64);
    @(negedge clk);
    yumi = 1'b0;
    chk("turn_ready", ready, 1'b1);
    push_block(blk_b);
    t_load_b = cyc;
    stream(100, 1'b0, '0, 64, n);
    chk("xfers_b", n, 64);
    chk("block_period", t_load_b - t_load_a, 65);
    @(negedge clk);
    yumi = 1'b0;

    // reset at round 30 with the old block still on block_i
    load_block(abc_blk);
    stream(100, 1'b0, '0, 30, n);
    @(negedge clk);
    yumi = 1'b0;
    chk("pre_rst_round", rnd, 6'd30);
    reset_n = 1'b0;
    v_i     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_v_o", v_o, 1'b0);
    chk("mid_rst_round", rnd, 6'd0);
    chk("mid_rst_wt", wt, 32'd0);
    chk("mid_rst_last", last, 1'b0);
    @(negedge clk);
    chk("post_rst_quiet", v_o, 1'b0);
    load_block(blk_b);
    stream(100, 1'b0, '0, 64, n);
    chk("xfers_restart", n, 64);
    @(negedge clk);
    yumi = 1'b0;
    chk("restart_done", ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
